// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one combinational-read memory between the core and the loader/debug port.
// The owner is registered; a bounded hold count stops either side from starving the other.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CORE, LDR} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_inc;

  // A grant needs both ownership and a live request, so an owner that drops req gets no access.
  assign core_gnt   = (state == CORE) & core_req;
  assign ldr_gnt    = (state == LDR) & ldr_req;
  assign core_stall = core_req & ~core_gnt;
  assign cnt_inc    = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + CNT_ONE;

  always_comb begin
    mem_adr = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    if (core_gnt) begin
      mem_adr = core_addr;
      mem_wd  = core_wdata;
      mem_we  = core_we;
    end else if (ldr_gnt) begin
      mem_adr = ldr_addr;
      mem_wd  = ldr_wdata;
      mem_we  = ldr_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      core_rvalid <= 1'b0;
      ldr_rvalid  <= 1'b0;
      core_rdata  <= '0;
      ldr_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      ldr_rvalid  <= ldr_gnt & ~ldr_we;
      if (core_gnt & ~core_we) core_rdata <= mem_rd;
      if (ldr_gnt & ~ldr_we) ldr_rdata <= mem_rd;

      // The other side takes over once the owner saturates its hold count or lets go.
      case (state)
        IDLE: begin
          if (core_req) begin
            state    <= CORE;
            hold_cnt <= CNT_ONE;
          end else if (ldr_req) begin
            state    <= LDR;
            hold_cnt <= CNT_ONE;
          end else begin
            hold_cnt <= '0;
          end
        end
        CORE: begin
          if (ldr_req && (hold_cnt == HOLD_MAX || !core_req)) begin
            state    <= LDR;
            hold_cnt <= CNT_ONE;
          end else if (core_req) begin
            hold_cnt <= cnt_inc;
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        LDR: begin
          if (core_req && (hold_cnt == HOLD_MAX || !ldr_req)) begin
            state    <= CORE;
            hold_cnt <= CNT_ONE;
          end else if (ldr_req) begin
            hold_cnt <= cnt_inc;
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios and then randomized traffic, checked against
// an ownership/streak model of the arbitration rules and a reference copy of memory.
module tb_mem_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       core_req, core_we, ldr_req, ldr_we;
  logic [7:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic       core_gnt, core_rvalid, core_stall, ldr_gnt, ldr_rvalid, mem_we;
  logic [7:0] core_rdata, ldr_rdata, mem_adr, mem_wd, mem_rd;
  logic       mem_init;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    own;
  int    streak;
  logic  exp_crv, exp_lrv;
  logic [7:0] exp_crd, exp_lrd;
  logic  last_cg, last_lg, obs_lg;
  string grant_log;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : 8'(i * 7 + 3);
  endfunction

  // Memory behind the arbiter: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_adr];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_adr] <= mem_wd;
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own     = 0;
    streak  = 0;
    exp_crv = 1'b0;
    exp_lrv = 1'b0;
    exp_crd = 8'h00;
    exp_lrd = 8'h00;
    last_cg = 1'b0;
    last_lg = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic apply_stimulus();
    logic e_cg, e_lg, e_we, mine, other;
    logic [7:0] e_adr, e_wd;
    #1;
    e_cg  = (own == 1) && core_req;
    e_lg  = (own == 2) && ldr_req;
    e_we  = (e_cg && core_we) || (e_lg && ldr_we);
    e_adr = e_cg ? core_addr : (e_lg ? ldr_addr : 8'h00);
    e_wd  = e_cg ? core_wdata : (e_lg ? ldr_wdata : 8'h00);
    obs_lg = ldr_gnt;
    check_output(e_cg, e_lg, e_we, e_adr, e_wd);
    grant_log = {grant_log, core_gnt ? "C" : (ldr_gnt ? "L" : "-")};

    exp_crv = e_cg && !core_we;
    exp_lrv = e_lg && !ldr_we;
    if (exp_crv) exp_crd = ref_mem[core_addr];
    if (exp_lrv) exp_lrd = ref_mem[ldr_addr];
    if (e_cg && core_we) ref_mem[core_addr] = core_wdata;
    if (e_lg && ldr_we) ref_mem[ldr_addr] = ldr_wdata;

    if (own == 0) begin
      if (core_req) begin own = 1; streak = 1; end
      else if (ldr_req) begin own = 2; streak = 1; end
    end else begin
      mine  = (own == 1) ? core_req : ldr_req;
      other = (own == 1) ? ldr_req : core_req;
      if (other && (streak == MAX_HOLD || !mine)) begin
        own    = 3 - own;
        streak = 1;
      end else if (mine) begin
        streak = (streak < MAX_HOLD) ? streak + 1 : MAX_HOLD;
      end else begin
        own    = 0;
        streak = 0;
      end
    end
    last_cg = e_cg;
    last_lg = e_lg;
    @(negedge clock);
  endtask

  task automatic check_output(input logic e_cg, input logic e_lg, input logic e_we,
                              input logic [7:0] e_adr, input logic [7:0] e_wd);
    check_bit("core_gnt", core_gnt, e_cg);
    check_bit("ldr_gnt", ldr_gnt, e_lg);
    check_bit("core_stall", core_stall, core_req && !e_cg);
    check_bit("mem_we", mem_we, e_we);
    check_byte("mem_adr", mem_adr, e_adr);
    if (e_we) check_byte("mem_wd", mem_wd, e_wd);
    check_bit("core_rvalid", core_rvalid, exp_crv);
    check_bit("ldr_rvalid", ldr_rvalid, exp_lrv);
    check_byte("core_rdata", core_rdata, exp_crd);
    check_byte("ldr_rdata", ldr_rdata, exp_lrd);
  endtask

  initial begin
    int waited;
    reset = 1'b1; mem_init = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    grant_log = "";
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (2) @(negedge clock);

    // Reset state.
    check_bit("rst_core_gnt", core_gnt, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_bit("rst_core_rvalid", core_rvalid, 1'b0);
    check_bit("rst_ldr_rvalid", ldr_rvalid, 1'b0);
    check_byte("rst_core_rdata", core_rdata, 8'h00);
    check_byte("rst_ldr_rdata", ldr_rdata, 8'h00);
    reset = 1'b0; mem_init = 1'b0;

    // 1: core read of 0x10 from IDLE.
    core_req = 1; core_we = 0; core_addr = 8'h10;
    apply_stimulus();
    apply_stimulus();
    check_byte("t1_rdata", core_rdata, 8'hA5);
    check_bit("t1_rvalid", core_rvalid, 1'b1);
    core_req = 0;
    apply_stimulus();
    apply_stimulus();

    // 2: loader write then read back.
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
    waited = 0;
    do begin apply_stimulus(); waited++; end while (!last_lg && waited < 5);
    check_bit("t2_wr_granted", last_lg, 1'b1);
    ldr_we = 0; ldr_wdata = 8'h00;
    waited = 0;
    do begin apply_stimulus(); waited++; end while (!last_lg && waited < 5);
    check_bit("t2_rd_granted", last_lg, 1'b1);
    ldr_req = 0;
    check_byte("t2_rdata", ldr_rdata, 8'h3C);
    apply_stimulus();

    // 3: simultaneous first request, core wins; loader follows when core lets go.
    core_req = 1; core_addr = 8'h01; ldr_req = 1; ldr_addr = 8'h02;
    apply_stimulus();
    apply_stimulus();
    check_bit("t3_core_first", last_cg, 1'b1);
    core_req = 0;
    apply_stimulus();
    core_req = 1; core_addr = 8'h03;
    apply_stimulus();
    check_bit("t3_ldr_after", obs_lg, 1'b1);
    core_req = 0; ldr_req = 0;
    apply_stimulus();
    apply_stimulus();

    // 4: both requesting continuously.
    grant_log = "";
    core_req = 1; ldr_req = 1;
    repeat (10) apply_stimulus();
    n_tests++;
    assert (grant_log == "-CCCCLLLLC") else begin
      n_fail++;
      $error("[TB] FAIL t4_pattern observed=%s expected=-CCCCLLLLC", grant_log);
    end
    core_req = 0; ldr_req = 0;
    apply_stimulus();
    apply_stimulus();

    // 5: reset pulse in the middle of a core grant cycle.
    core_req = 1; core_we = 0; core_addr = 8'h05;
    apply_stimulus();
    #1;
    check_bit("t5_pre_gnt", core_gnt, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("t5_core_gnt", core_gnt, 1'b0);
    check_bit("t5_mem_we", mem_we, 1'b0);
    check_bit("t5_rvalid", core_rvalid, 1'b0);
    check_byte("t5_rdata", core_rdata, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    apply_stimulus();
    apply_stimulus();
    check_bit("t5_regrant", last_cg, 1'b1);
    core_req = 0;
    apply_stimulus();

    // 6: core holds alone for 10 cycles, then the loader arrives.
    core_req = 1;
    for (int i = 0; i < 10; i++) begin
      core_addr = 8'($urandom_range(0, 15));
      apply_stimulus();
    end
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h07;
    apply_stimulus();
    apply_stimulus();
    check_bit("t6_ldr_gnt", obs_lg, 1'b1);
    core_req = 0; ldr_req = 0;
    apply_stimulus();
    apply_stimulus();

    // Randomized traffic, keeping each request stable until it is granted.
    for (int i = 0; i < 400; i++) begin
      if (!core_req || last_cg) begin
        core_req   = ($urandom_range(0, 99) < 60);
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = 8'($urandom_range(0, 15));
        core_wdata = 8'($urandom);
      end
      if (!ldr_req || last_lg) begin
        ldr_req   = ($urandom_range(0, 99) < 50);
        ldr_we    = $urandom_range(0, 1) == 1;
        ldr_addr  = 8'($urandom_range(0, 15));
        ldr_wdata = 8'($urandom);
      end
      apply_stimulus();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
